// File: rtl/cache_sim_pkg.sv
// Shared encodings and geometry for the trace-driven direct-mapped cache controller.
package cache_sim_pkg;

  localparam int OFFSET_W      = 4;
  localparam int INDEX_W       = 4;
  localparam int TAG_W         = 24;
  localparam int ADDR_W        = 32;
  localparam int CNT_W         = 16;
  localparam int DEF_MISS_LAT  = 4;
  localparam int DEF_TRACE_LEN = 10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_LOOKUP = 3'd3,
    ST_MISS   = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/cache_tag_array.sv
// Valid/tag store for a direct-mapped cache: combinational read, clocked write and clear-all.
module cache_tag_array
  import cache_sim_pkg::*;
#(
  parameter int NUM_LINES = 16,
  localparam int LINE_W = $clog2(NUM_LINES)
) (
  input  logic              clk,
  input  logic              clr_i,
  input  logic              we_i,
  input  logic [LINE_W-1:0] waddr_i,
  input  logic [TAG_W-1:0]  wtag_i,
  input  logic [LINE_W-1:0] raddr_i,
  output logic              rvalid_o,
  output logic [TAG_W-1:0]  rtag_o
);

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q [NUM_LINES];

  // Clear wins over a same-cycle write so a fresh run never sees stale lines.
  always_ff @(posedge clk) begin
    if (clr_i) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[waddr_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_q[waddr_i] <= wtag_i;
    end
  end

  assign rvalid_o = valid_q[raddr_i];
  assign rtag_o   = tag_q[raddr_i];

endmodule

// File: rtl/trace_cache_ctrl.sv
// Replays TRACE_LEN trace addresses through a direct-mapped tag store, counting hits and misses.
//   state  | meaning
//   IDLE   | after reset, waiting for start
//   REQ    | pulse updated to ask the source for the next address
//   WAIT   | hold until trace_ready, capture mem_addr
//   LOOKUP | compare tag, count hit or miss, fill line on miss
//   MISS   | stall MISS_LAT cycles
//   DONE   | run complete, done held until next start
module trace_cache_ctrl
  import cache_sim_pkg::*;
#(
  parameter int TRACE_LEN = DEF_TRACE_LEN,
  parameter int MISS_LAT  = DEF_MISS_LAT,
  parameter int NUM_LINES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              trace_ready,
  input  logic [ADDR_W-1:0] mem_addr,
  output logic              updated,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int LINE_W = $clog2(NUM_LINES);
  localparam int BLK_W  = ADDR_W - OFFSET_W;

  state_e             state_q, state_d;
  logic [BLK_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   hit_q, hit_d;
  logic [CNT_W-1:0]   miss_q, miss_d;
  logic [3:0]         stall_q, stall_d;

  logic               start_acc;
  logic               hit;
  logic               rvalid;
  logic [TAG_W-1:0]   rtag;
  logic [LINE_W-1:0]  line_idx;
  logic [TAG_W-1:0]   addr_tag;
  logic [CNT_W-1:0]   acc_next;
  logic               unused_offset;

  // Byte offset within a line never affects lookup.
  assign unused_offset = ^mem_addr[OFFSET_W-1:0];

  assign line_idx  = addr_q[LINE_W-1:0];
  assign addr_tag  = addr_q[BLK_W-1 -: TAG_W];
  assign hit       = rvalid && (rtag == addr_tag);
  assign acc_next  = acc_q + 1'b1;
  assign start_acc = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  cache_tag_array #(
    .NUM_LINES (NUM_LINES)
  ) u_tags (
    .clk      (clk),
    .clr_i    (reset || start_acc),
    .we_i     ((state_q == ST_LOOKUP) && !hit),
    .waddr_i  (line_idx),
    .wtag_i   (addr_tag),
    .raddr_i  (line_idx),
    .rvalid_o (rvalid),
    .rtag_o   (rtag)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = ST_REQ;
      ST_REQ:           state_d = ST_WAIT;
      ST_WAIT:          if (trace_ready) state_d = ST_LOOKUP;
      ST_LOOKUP: begin
        if (!hit)                            state_d = ST_MISS;
        else if (acc_next == CNT_W'(TRACE_LEN)) state_d = ST_DONE;
        else                                 state_d = ST_REQ;
      end
      ST_MISS: begin
        if (stall_q == 4'd0) begin
          state_d = (acc_q == CNT_W'(TRACE_LEN)) ? ST_DONE : ST_REQ;
        end
      end
      default:          state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    updated = (state_q == ST_REQ);
    busy    = (state_q == ST_REQ) || (state_q == ST_WAIT) ||
              (state_q == ST_LOOKUP) || (state_q == ST_MISS);
    done    = (state_q == ST_DONE);
  end

  always_comb begin
    addr_d  = addr_q;
    acc_d   = acc_q;
    hit_d   = hit_q;
    miss_d  = miss_q;
    stall_d = stall_q;
    if (start_acc) begin
      acc_d  = '0;
      hit_d  = '0;
      miss_d = '0;
    end
    case (state_q)
      ST_WAIT: if (trace_ready) addr_d = mem_addr[ADDR_W-1:OFFSET_W];
      ST_LOOKUP: begin
        acc_d   = acc_next;
        stall_d = 4'(MISS_LAT - 1);
        if (hit) hit_d  = sat_inc(hit_q);
        else     miss_d = sat_inc(miss_q);
      end
      ST_MISS: if (stall_q != 4'd0) stall_d = stall_q - 4'd1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      acc_q   <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
      stall_q <= '0;
    end else begin
      addr_q  <= addr_d;
      acc_q   <= acc_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      stall_q <= stall_d;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;

endmodule

// File: tb/tb_trace_cache_ctrl.sv
// Directed bench for trace_cache_ctrl with default TRACE_LEN=10, MISS_LAT=4.
module tb_trace_cache_ctrl;
  import cache_sim_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        trace_ready;
  logic [31:0] mem_addr;
  logic        updated;
  logic        busy;
  logic        done;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  int n_chk = 0;
  int n_bad = 0;
  int upd_cnt = 0;

  trace_cache_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .trace_ready (trace_ready),
    .mem_addr    (mem_addr),
    .updated     (updated),
    .busy        (busy),
    .done        (done),
    .hit_count   (hit_count),
    .miss_count  (miss_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (updated) upd_cnt++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One trace transaction: wait for updated, optionally stall the source, present addr,
  // then measure cycles from the accepting WAIT cycle to the next updated or done.
  task automatic access(input logic [31:0] addr, input int delay, input bit stray,
                        output int gap);
    int n;
    bit upd_seen;
    n = 0;
    while (!updated && n < 60) begin
      tick();
      n++;
    end
    chk("req_seen", 32'(updated), 32'd1);
    tick();
    upd_seen = 1'b0;
    for (int i = 0; i < delay; i++) begin
      upd_seen |= updated;
      tick();
    end
    if (delay > 0) begin
      chk("wait_no_upd", 32'(upd_seen), 32'd0);
      chk("wait_state", 32'(dut.state_q), 32'(ST_WAIT));
    end
    trace_ready = 1'b1;
    mem_addr    = addr;
    tick();
    trace_ready = 1'b0;
    mem_addr    = 32'h0;
    gap = 1;
    while (!updated && !done && gap < 60) begin
      if (stray) begin
        trace_ready = 1'b1;
        mem_addr    = 32'hDEAD_BEE0;
        start       = 1'b1;
      end
      tick();
      gap++;
    end
    trace_ready = 1'b0;
    start       = 1'b0;
  endtask

  logic [31:0] tr1 [10];
  bit          ms1 [10];
  logic [31:0] tr2 [10];
  bit          ms2 [10];

  initial begin
    int gap;
    int eh;
    int em;
    int u0;

    tr1 = '{32'h04432090, 32'h04432091, 32'h04432092, 32'h04432093, 32'h04432094,
            32'h04432095, 32'h04432096, 32'h04432097, 32'h04432090, 32'h04432FC5};
    ms1 = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tr2 = '{32'h00000010, 32'h00001010, 32'h00000010, 32'h00000010, 32'h00000010,
            32'h00000010, 32'h00000010, 32'h00000010, 32'h00000010, 32'h00000010};
    ms2 = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    reset = 1'b1; start = 1'b0; trace_ready = 1'b0; mem_addr = 32'h0;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_upd", 32'(updated), 32'd0);
    chk("rst_hits", 32'(hit_count), 32'd0);
    chk("rst_miss", 32'(miss_count), 32'd0);
    reset = 1'b0;
    tick();

    // stray trace_ready in IDLE
    trace_ready = 1'b1; mem_addr = 32'h04432090;
    tick();
    tick();
    trace_ready = 1'b0;
    chk("idle_state", 32'(dut.state_q), 32'(ST_IDLE));
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_upd_cnt", 32'(upd_cnt), 32'd0);
    chk("idle_hits", 32'(hit_count), 32'd0);

    // run 1: sequential line, one re-hit, one far miss; access 3 has a slow source
    u0 = upd_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("r1_busy", 32'(busy), 32'd1);
    eh = 0; em = 0;
    for (int i = 0; i < 10; i++) begin
      access(tr1[i], (i == 3) ? 5 : 0, 1'b0, gap);
      if (ms1[i]) em++; else eh++;
      chk($sformatf("r1_gap%0d", i), 32'(gap), ms1[i] ? 32'd6 : 32'd2);
      chk($sformatf("r1_hit%0d", i), 32'(hit_count), 32'(eh));
      chk($sformatf("r1_miss%0d", i), 32'(miss_count), 32'(em));
    end
    chk("r1_done", 32'(done), 32'd1);
    chk("r1_busy_end", 32'(busy), 32'd0);
    chk("r1_upd_cnt", 32'(upd_cnt - u0), 32'd10);
    tick();
    tick();
    chk("r1_done_held", 32'(done), 32'd1);
    chk("r1_hits_held", 32'(hit_count), 32'd8);

    // run 2: conflicting tags on index 1, stray inputs during the first miss stall
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("r2_hits_clr", 32'(hit_count), 32'd0);
    chk("r2_miss_clr", 32'(miss_count), 32'd0);
    chk("r2_done_clr", 32'(done), 32'd0);
    eh = 0; em = 0;
    for (int i = 0; i < 10; i++) begin
      access(tr2[i], 0, i == 0, gap);
      if (ms2[i]) em++; else eh++;
      chk($sformatf("r2_gap%0d", i), 32'(gap), ms2[i] ? 32'd6 : 32'd2);
      chk($sformatf("r2_hit%0d", i), 32'(hit_count), 32'(eh));
      chk($sformatf("r2_miss%0d", i), 32'(miss_count), 32'(em));
    end
    chk("r2_done", 32'(done), 32'd1);

    // run 3: reset in the first MISS cycle aborts the run
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("r3_req", 32'(updated), 32'd1);
    tick();
    trace_ready = 1'b1; mem_addr = 32'h00000010;
    tick();
    trace_ready = 1'b0;
    tick();
    chk("r3_miss_state", 32'(dut.state_q), 32'(ST_MISS));
    chk("r3_remiss", 32'(miss_count), 32'd1);
    reset = 1'b1;
    u0 = upd_cnt;
    tick();
    reset = 1'b0;
    chk("r3_rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    chk("r3_rst_busy", 32'(busy), 32'd0);
    chk("r3_rst_done", 32'(done), 32'd0);
    chk("r3_rst_upd", 32'(updated), 32'd0);
    chk("r3_rst_miss", 32'(miss_count), 32'd0);
    tick();
    tick();
    chk("r3_no_upd", 32'(upd_cnt - u0), 32'd0);

    start = 1'b1;
    tick();
    start = 1'b0;
    access(32'h00000010, 0, 1'b0, gap);
    chk("r4_gap", 32'(gap), 32'd6);
    chk("r4_miss", 32'(miss_count), 32'd1);
    chk("r4_hits", 32'(hit_count), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
